cpu_top: RTL and testbench

- Single-cycle 64-bit RISC-V (RV64I subset) processor core with an internal instruction ROM, a 32x64 register file and a doubleword data memory.
- Has no external data ports. It runs a fixed built-in program after reset.
- Verification inspects internal state hierarchically:
  - register-file instance RF, array regs[0:31]
  - data-memory instance DM, array mem[0:DMEM_WORDS-1]

---
 rtl/cpu_top.sv | 147 ++++++++++++++
 tb/tb_cpu_top.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_top.sv
// rtl/cpu_top.sv - single-cycle RV64I-subset core with built-in program ROM, register file and data memory
module cpu_regfile #(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_we,
    input  logic [4:0]      i_rd,
    input  logic [4:0]      i_rs1,
    input  logic [4:0]      i_rs2,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_rs1_data,
    output logic [XLEN-1:0] o_rs2_data
);
    logic [XLEN-1:0] regs [0:31];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (i_we && i_rd != 5'd0) begin
            regs[i_rd] <= i_wdata;
        end
    end

    assign o_rs1_data = (i_rs1 == 5'd0) ? '0 : regs[i_rs1];
    assign o_rs2_data = (i_rs2 == 5'd0) ? '0 : regs[i_rs2];
endmodule

module cpu_dmem #(
    parameter int XLEN       = 64,
    parameter int DMEM_WORDS = 32,
    parameter int AW         = $clog2(DMEM_WORDS)
) (
    input  logic            i_clk,
    input  logic            i_we,
    input  logic [AW-1:0]   i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic [XLEN-1:0] o_rdata
);
    // Deliberately not reset: contents survive a core reset.
    logic [XLEN-1:0] mem [0:DMEM_WORDS-1];

    always_ff @(posedge i_clk) begin
        if (i_we) mem[i_addr] <= i_wdata;
    end

    assign o_rdata = mem[i_addr];
endmodule

module cpu_top #(
    parameter int XLEN       = 64,
    parameter int IMEM_WORDS = 64,
    parameter int DMEM_WORDS = 32
) (
    input logic clk,
    input logic rst
);
    localparam int IM_AW = $clog2(IMEM_WORDS);
    localparam int DM_AW = $clog2(DMEM_WORDS);

    logic [XLEN-1:0] r_pc;
    logic [31:0]     w_inst;
    logic [6:0]      w_opcode;
    logic [4:0]      w_rd, w_rs1, w_rs2;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b;
    logic [XLEN-1:0] w_rs1_data, w_rs2_data, w_addr, w_dm_rdata;
    logic [XLEN-1:0] w_wdata, w_next_pc;
    logic            w_rf_we, w_dm_we;
    logic            w_unused;

    function automatic logic [31:0] rom(input logic [IM_AW-1:0] idx);
        case (int'(idx))
            0:       rom = 32'h00A00293; // addi x5,x0,10
            1:       rom = 32'h00300313; // addi x6,x0,3
            2:       rom = 32'h00628233; // add  x4,x5,x6
            3:       rom = 32'h40628F33; // sub  x30,x5,x6
            4:       rom = 32'h06403823; // sd   x4,112(x0)
            5:       rom = 32'h07003803; // ld   x16,112(x0)
            6:       rom = 32'h00500013; // addi x0,x0,5
            7:       rom = 32'h00480463; // beq  x16,x4,+8
            8:       rom = 32'h06300813; // addi x16,x0,99
            9:       rom = 32'h01E80833; // add  x16,x16,x30
            10:      rom = 32'h00000063; // beq  x0,x0,0
            default: rom = 32'h00000013;
        endcase
    endfunction

    assign w_inst   = rom(r_pc[IM_AW+1:2]);
    assign w_opcode = w_inst[6:0];
    assign w_rd     = w_inst[11:7];
    assign w_f3     = w_inst[14:12];
    assign w_rs1    = w_inst[19:15];
    assign w_rs2    = w_inst[24:20];
    assign w_f7     = w_inst[31:25];
    assign w_imm_i  = {{(XLEN-12){w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s  = {{(XLEN-12){w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b  = {{(XLEN-13){w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_addr   = w_rs1_data + ((w_opcode == 7'b0100011) ? w_imm_s : w_imm_i);
    assign w_unused = ^{w_addr[XLEN-1:DM_AW+3], w_addr[2:0]};

    cpu_regfile #(.XLEN(XLEN)) RF (
        .i_clk(clk), .i_rst(rst), .i_we(w_rf_we), .i_rd(w_rd), .i_rs1(w_rs1), .i_rs2(w_rs2),
        .i_wdata(w_wdata), .o_rs1_data(w_rs1_data), .o_rs2_data(w_rs2_data)
    );

    cpu_dmem #(.XLEN(XLEN), .DMEM_WORDS(DMEM_WORDS)) DM (
        .i_clk(clk), .i_we(w_dm_we), .i_addr(w_addr[DM_AW+2:3]),
        .i_wdata(w_rs2_data), .o_rdata(w_dm_rdata)
    );

    always_comb begin
        w_rf_we   = 1'b0;
        w_dm_we   = 1'b0;
        w_wdata   = '0;
        w_next_pc = r_pc + XLEN'(4);
        case (w_opcode)
            7'b0110011: begin
                w_rf_we = 1'b1;
                case ({w_f7, w_f3})
                    10'b0000000_000: w_wdata = w_rs1_data + w_rs2_data;
                    10'b0100000_000: w_wdata = w_rs1_data - w_rs2_data;
                    10'b0000000_111: w_wdata = w_rs1_data & w_rs2_data;
                    10'b0000000_110: w_wdata = w_rs1_data | w_rs2_data;
                    default:         w_rf_we = 1'b0;
                endcase
            end
            7'b0010011: if (w_f3 == 3'b000) begin
                w_rf_we = 1'b1;
                w_wdata = w_rs1_data + w_imm_i;
            end
            7'b0000011: if (w_f3 == 3'b011) begin
                w_rf_we = 1'b1;
                w_wdata = w_dm_rdata;
            end
            7'b0100011: if (w_f3 == 3'b011) w_dm_we = 1'b1;
            7'b1100011: if (w_f3 == 3'b000 && w_rs1_data == w_rs2_data) w_next_pc = r_pc + w_imm_b;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_pc <= '0;
        else     r_pc <= w_next_pc;
    end
endmodule

// File: tb/tb_cpu_top.sv
// tb/tb_cpu_top.sv - scoreboard bench for cpu_top against an instruction-level reference model
module tb_cpu_top;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_top dut (.clk(clk), .rst(rst));

    typedef enum {OP_NOP, OP_ADDI, OP_ADD, OP_SUB, OP_SD, OP_LD, OP_BEQ} op_e;
    typedef struct {op_e op; int rd; int rs1; int rs2; longint imm;} ins_t;
    typedef struct packed {
        logic [63:0]       pc;
        logic [31:0][63:0] regs;
        logic [31:0][63:0] mem;
        logic [31:0]       memv;
    } exp_t;

    ins_t        prog [11];
    logic [63:0] m_pc;
    logic [63:0] m_regs [32];
    logic [63:0] m_mem [32];
    bit          m_memv [32];
    exp_t        q [$];
    int          errors = 0;
    int          checks = 0;

    function automatic ins_t mk(op_e op, int rd, int rs1, int rs2, longint imm);
        ins_t r;
        r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    task automatic model_step(input bit r);
        ins_t in;
        logic [63:0] a, b, addr, nxt, res;
        int idx, wi;
        bit wr;
        if (r) begin
            m_pc = 0;
            for (int i = 0; i < 32; i++) m_regs[i] = 0;
        end else begin
            idx = int'(m_pc) / 4;
            in  = (idx < 11) ? prog[idx] : mk(OP_NOP, 0, 0, 0, 0);
            a   = m_regs[in.rs1];
            b   = m_regs[in.rs2];
            nxt = m_pc + 4;
            res = 0;
            wr  = 0;
            addr = a + 64'(in.imm);
            wi  = int'((addr / 8) % 32);
            case (in.op)
                OP_ADDI: begin res = a + 64'(in.imm); wr = 1; end
                OP_ADD:  begin res = a + b; wr = 1; end
                OP_SUB:  begin res = a - b; wr = 1; end
                OP_LD:   begin res = m_mem[wi]; wr = 1; end
                OP_SD:   begin m_mem[wi] = b; m_memv[wi] = 1; end
                OP_BEQ:  if (a == b) nxt = m_pc + 64'(in.imm);
                default: ;
            endcase
            if (wr && in.rd != 0) m_regs[in.rd] = res;
            m_pc = nxt;
        end
    endtask

    task automatic cyc(input bit r);
        exp_t e;
        @(negedge clk) rst = r;
        @(posedge clk);
        model_step(r);
        e.pc = m_pc;
        for (int i = 0; i < 32; i++) begin
            e.regs[i] = m_regs[i];
            e.mem[i]  = m_mem[i];
            e.memv[i] = m_memv[i];
        end
        q.push_back(e);
    endtask

    task automatic run(input bit r, input int n);
        for (int i = 0; i < n; i++) cyc(r);
    endtask

    task automatic final_check();
        @(negedge clk);
        chk("final_pc", dut.r_pc, 64'd40);
        chk("final_x0", dut.RF.regs[0], 64'd0);
        chk("final_x4", dut.RF.regs[4], 64'd13);
        chk("final_x5", dut.RF.regs[5], 64'd10);
        chk("final_x6", dut.RF.regs[6], 64'd3);
        chk("final_x16", dut.RF.regs[16], 64'd20);
        chk("final_x30", dut.RF.regs[30], 64'd7);
        chk("final_mem14", dut.DM.mem[14], 64'd13);
    endtask

    // Monitor: compares the post-edge architectural state against the next queued expectation.
    initial begin
        exp_t e;
        int bad;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", dut.r_pc, e.pc);
                bad = -1;
                for (int i = 0; i < 32; i++)
                    if (bad < 0 && dut.RF.regs[i] !== e.regs[i]) bad = i;
                checks++;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL rf x%0d: got %0d expected %0d", bad, dut.RF.regs[bad], e.regs[bad]);
                end
                bad = -1;
                for (int i = 0; i < 32; i++)
                    if (bad < 0 && e.memv[i] && dut.DM.mem[i] !== e.mem[i]) bad = i;
                checks++;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL dm mem[%0d]: got %0d expected %0d", bad, dut.DM.mem[bad], e.mem[bad]);
                end
            end
        end
    end

    initial begin
        int n;
        prog[0]  = mk(OP_ADDI, 5, 0, 0, 10);
        prog[1]  = mk(OP_ADDI, 6, 0, 0, 3);
        prog[2]  = mk(OP_ADD, 4, 5, 6, 0);
        prog[3]  = mk(OP_SUB, 30, 5, 6, 0);
        prog[4]  = mk(OP_SD, 0, 0, 4, 112);
        prog[5]  = mk(OP_LD, 16, 0, 0, 112);
        prog[6]  = mk(OP_ADDI, 0, 0, 0, 5);
        prog[7]  = mk(OP_BEQ, 0, 16, 4, 8);
        prog[8]  = mk(OP_ADDI, 16, 0, 0, 99);
        prog[9]  = mk(OP_ADD, 16, 16, 30, 0);
        prog[10] = mk(OP_BEQ, 0, 0, 0, 0);
        m_pc = 0;
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 0; m_mem[i] = 0; m_memv[i] = 0;
        end

        run(1, 2);
        run(0, 25);
        final_check();

        run(1, 1);
        run(0, 4);
        run(1, 1);
        run(0, 25);
        final_check();

        run(1, 10);
        run(0, 15);

        for (int ep = 0; ep < 6; ep++) begin
            n = int'($urandom_range(0, 14));
            run(0, n);
            n = int'($urandom_range(1, 3));
            run(1, n);
        end
        run(0, 20);
        final_check();
        run(0, 50);
        final_check();

        n = 0;
        while (q.size() > 0 && n < 5) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
